// File: rtl/cache_tag_store.sv
// Set-associative tag store: tag compare, tree-PLRU victim choice, fills/invalidates and a sequenced flush.
// Response is registered one cycle after accept; lookups stall (lookup_ready=0) only while a flush runs.
module cache_tag_store #(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int TAG_WIDTH = 23,
  parameter int IDX_WIDTH = $clog2(SETS),
  parameter int WAY_WIDTH = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup_valid,
  output logic                 lookup_ready,
  input  logic [IDX_WIDTH-1:0] lookup_set,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_WIDTH-1:0] resp_hit_way,
  output logic [WAY_WIDTH-1:0] resp_victim_way,
  output logic                 resp_victim_valid,
  input  logic                 fill_valid,
  input  logic [IDX_WIDTH-1:0] fill_set,
  input  logic [WAY_WIDTH-1:0] fill_way,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_inval,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done
);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] flush_idx_q, flush_idx_d;
  logic                 done_q, done_d;

  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [WAYS-2:0]      plru_d  [SETS];

  logic                 resp_valid_q, resp_hit_q, resp_victim_valid_q;
  logic [WAY_WIDTH-1:0] resp_hit_way_q, resp_victim_way_q;

  logic                 accept, fill_en;
  logic [WAYS-1:0]      match;
  logic                 hit, any_inv;
  logic [WAY_WIDTH-1:0] hit_way, inv_way, victim_way;

  // Walk root-to-leaf along the way's index bits, pointing each node away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree_in,
                                                 input logic [WAY_WIDTH-1:0] way);
    logic [WAYS-2:0]      tree;
    logic [WAY_WIDTH-1:0] node;
    tree = tree_in;
    node = '0;
    for (int l = WAY_WIDTH - 1; l >= 0; l--) begin
      tree[node] = ~way[l];
      node = WAY_WIDTH'(2 * int'(node) + 1 + int'(way[l]));
    end
    return tree;
  endfunction

  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WAY_WIDTH-1:0] node;
    logic [WAY_WIDTH-1:0] way;
    node = '0;
    way  = '0;
    for (int l = WAY_WIDTH - 1; l >= 0; l--) begin
      way[l] = tree[node];
      node = WAY_WIDTH'(2 * int'(node) + 1 + int'(tree[node]));
    end
    return way;
  endfunction

  assign flush_busy   = (state_q == FLUSH);
  assign lookup_ready = !flush_busy;
  assign flush_done   = done_q;
  assign accept       = lookup_valid && lookup_ready;
  assign fill_en      = fill_valid && !flush_busy;

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        if (flush_idx_q == IDX_WIDTH'(SETS - 1)) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          flush_idx_d = '0;
        end else begin
          flush_idx_d = flush_idx_q + IDX_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Compare against the array as it stands this cycle; same-cycle fills land afterwards.
  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[lookup_set][w] && (tag_q[lookup_set][w] == lookup_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_WIDTH'(w);
      if (!valid_q[lookup_set][w]) inv_way = WAY_WIDTH'(w);
    end
    hit        = |match;
    any_inv    = ~&valid_q[lookup_set];
    victim_way = any_inv ? inv_way : plru_victim(plru_q[lookup_set]);
  end

  // Fill is applied after the hit update so a same-set fill replaces the hit's PLRU state.
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (state_q == FLUSH) begin
      valid_d[flush_idx_q] = '0;
      plru_d[flush_idx_q]  = '0;
    end else begin
      if (accept && hit) plru_d[lookup_set] = plru_touch(plru_q[lookup_set], hit_way);
      if (fill_en) begin
        if (fill_inval) begin
          valid_d[fill_set][fill_way] = 1'b0;
        end else begin
          valid_d[fill_set][fill_way] = 1'b1;
          plru_d[fill_set]            = plru_touch(plru_q[fill_set], fill_way);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      done_q      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      plru_q      <= plru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en && !fill_inval) tag_q[fill_set][fill_way] <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q        <= 1'b0;
      resp_hit_q          <= 1'b0;
      resp_hit_way_q      <= '0;
      resp_victim_way_q   <= '0;
      resp_victim_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_hit_q          <= hit;
        resp_hit_way_q      <= hit_way;
        resp_victim_way_q   <= victim_way;
        resp_victim_valid_q <= valid_q[lookup_set][victim_way];
      end
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_hit          = resp_hit_q;
  assign resp_hit_way      = resp_hit_way_q;
  assign resp_victim_way   = resp_victim_way_q;
  assign resp_victim_valid = resp_victim_valid_q;

  no_fill_during_flush: assert property (@(posedge clk) disable iff (!rst_n)
                                         !(fill_valid && flush_busy));

endmodule

// File: tb/tb_cache_tag_store.sv
// Directed bench for cache_tag_store with a set-level reference model checked every cycle.
module tb_cache_tag_store;
  localparam int WAYS = 4, SETS = 16, TW = 23, IW = 4, WW = 2, LOG = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          lookup_valid = 1'b0, lookup_ready;
  logic [IW-1:0] lookup_set = '0;
  logic [TW-1:0] lookup_tag = '0;
  logic          resp_valid, resp_hit, resp_victim_valid;
  logic [WW-1:0] resp_hit_way, resp_victim_way;
  logic          fill_valid = 1'b0, fill_inval = 1'b0;
  logic [IW-1:0] fill_set = '0;
  logic [WW-1:0] fill_way = '0;
  logic [TW-1:0] fill_tag = '0;
  logic          flush_req = 1'b0, flush_busy, flush_done;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cache_tag_store #(.WAYS(WAYS), .SETS(SETS), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_set(lookup_set), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_hit_way(resp_hit_way),
    .resp_victim_way(resp_victim_way), .resp_victim_valid(resp_victim_valid),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_inval(fill_inval),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-set valid/tag tables and PLRU node bits addressed by (level, prefix).
  bit            m_valid [SETS][WAYS];
  logic [TW-1:0] m_tag   [SETS][WAYS];
  bit            m_node  [SETS][WAYS];
  bit            m_busy, m_done;
  int            m_idx;
  bit            e_rv, e_hit, e_vv;
  int            e_hw, e_vw;
  bit            m_acc, m_fill, m_h;
  int            m_s, m_hw, m_vw;

  function automatic int m_victim(input int s);
    int v = 0;
    for (int l = 0; l < LOG; l++) v = v * 2 + int'(m_node[s][(1 << l) - 1 + v]);
    return v;
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < LOG; l++)
      m_node[s][(1 << l) - 1 + (w >> (LOG - l))] = !((w >> (LOG - 1 - l)) & 1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          m_valid[s][w] = 0;
          m_node[s][w]  = 0;
        end
      m_busy = 0; m_done = 0; m_idx = 0;
      e_rv = 0; e_hit = 0; e_vv = 0; e_hw = 0; e_vw = 0;
    end else begin
      m_acc  = lookup_valid && !m_busy;
      m_fill = fill_valid && !m_busy;
      m_s    = int'(lookup_set);
      e_rv   = m_acc;
      if (m_acc) begin
        m_h = 0; m_hw = 0; m_vw = -1;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (m_valid[m_s][w] && m_tag[m_s][w] == lookup_tag) begin m_h = 1; m_hw = w; end
          if (!m_valid[m_s][w]) m_vw = w;
        end
        if (m_vw < 0) m_vw = m_victim(m_s);
        e_hit = m_h; e_hw = m_hw; e_vw = m_vw; e_vv = m_valid[m_s][m_vw];
        if (m_h && !(m_fill && !fill_inval && int'(fill_set) == m_s)) m_touch(m_s, m_hw);
      end
      if (m_fill) begin
        if (fill_inval) m_valid[fill_set][fill_way] = 0;
        else begin
          m_valid[fill_set][fill_way] = 1;
          m_tag[fill_set][fill_way]   = fill_tag;
          m_touch(int'(fill_set), int'(fill_way));
        end
      end
      m_done = 0;
      if (m_busy) begin
        for (int w = 0; w < WAYS; w++) begin
          m_valid[m_idx][w] = 0;
          m_node[m_idx][w]  = 0;
        end
        if (m_idx == SETS - 1) begin m_busy = 0; m_done = 1; m_idx = 0; end
        else m_idx++;
      end else if (flush_req) begin
        m_busy = 1; m_idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_hit", resp_hit, e_hit);
    chk("resp_hit_way", resp_hit_way, e_hw);
    chk("resp_victim_way", resp_victim_way, e_vw);
    chk("resp_victim_valid", resp_victim_valid, e_vv);
    chk("lookup_ready", lookup_ready, !m_busy);
    chk("flush_busy", flush_busy, m_busy);
    chk("flush_done", flush_done, m_done);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lookup(input int s, input int t);
    lookup_valid = 1; lookup_set = IW'(s); lookup_tag = TW'(t);
    cyc();
    lookup_valid = 0;
    @(negedge clk);
  endtask

  task automatic fill(input int s, input int w, input int t, input bit inval);
    fill_valid = 1; fill_set = IW'(s); fill_way = WW'(w); fill_tag = TW'(t); fill_inval = inval;
    cyc();
    fill_valid = 0; fill_inval = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, done_at, done_seen;
    repeat (2) @(negedge clk);
    chk("rst_ready", lookup_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", flush_busy, 0);
    #2 rst_n = 1;
    cyc();

    lookup(3, 'h1234);
    chk("t1_rv", resp_valid, 1);
    chk("t1_hit", resp_hit, 0);
    chk("t1_vw", resp_victim_way, 0);
    chk("t1_vv", resp_victim_valid, 0);

    for (int w = 0; w < 4; w++) fill(5, w, 'hA0 + w, 0);
    lookup(5, 'hA2);
    chk("t2_hit", resp_hit, 1);
    chk("t2_hw", resp_hit_way, 2);
    lookup(5, 'hFF);
    chk("t2_miss", resp_hit, 0);
    chk("t2_vv", resp_victim_valid, 1);
    chk("t2_vw", resp_victim_way, 0);

    for (int w = 0; w < 4; w++) lookup(5, 'hA0 + w);
    lookup(5, 'hFF);
    chk("t3_vw_a", resp_victim_way, 0);
    lookup(5, 'hA0);
    lookup(5, 'hFF);
    chk("t3_vw_b", resp_victim_way, 2);

    // Hit on way 2 and fill of way 1 in set 5 together: only the fill's PLRU update survives.
    lookup_valid = 1; lookup_set = 5; lookup_tag = 'hA2;
    fill(5, 1, 'hA1, 0);
    lookup_valid = 0;
    @(negedge clk);
    chk("t4_hit", resp_hit, 1);
    chk("t4_hw", resp_hit_way, 2);
    lookup(5, 'hFF);
    chk("t4_vw", resp_victim_way, 2);

    // Different sets in the same cycle: both updates apply.
    lookup_valid = 1; lookup_set = 5; lookup_tag = 'hA3;
    fill(9, 2, 'h77, 0);
    lookup_valid = 0;
    @(negedge clk);
    chk("t4b_hw", resp_hit_way, 3);

    fill(5, 1, 0, 1);
    lookup(5, 'hFF);
    chk("t5_vw", resp_victim_way, 1);
    chk("t5_vv", resp_victim_valid, 0);
    lookup(5, 'hA1);
    chk("t5_inval_miss", resp_hit, 0);

    lookup_valid = 1; lookup_set = 7; lookup_tag = 'hB0;
    fill(7, 1, 'hB0, 0);
    lookup_valid = 0;
    @(negedge clk);
    chk("t6_same_cycle_miss", resp_hit, 0);
    lookup(7, 'hB0);
    chk("t6_hit", resp_hit, 1);
    chk("t6_hw", resp_hit_way, 1);

    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) fill(s, w, 'h100 + s * 4 + w, 0);
    flush_req = 1; lookup_valid = 1; lookup_set = 0; lookup_tag = 'h100;
    cyc();
    flush_req = 0; lookup_valid = 0;
    @(negedge clk);
    chk("t7_preflush_hit", resp_hit, 1);
    chk("t7_preflush_hw", resp_hit_way, 0);
    busy_cnt = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      if (flush_done) begin done_at = k; break; end
      if (flush_busy) busy_cnt++;
      @(negedge clk);
    end
    chk("t7_busy_cycles", busy_cnt, 16);
    chk("t7_done_cycle", done_at, 17);
    for (int i = 0; i < 4; i++) begin
      lookup(i * 5, 'h100 + i * 20);
      chk("t7_post_miss", resp_hit, 0);
      chk("t7_post_vw", resp_victim_way, 0);
    end

    fill(2, 3, 'h55, 0);
    flush_req = 1;
    cyc();
    flush_req = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t8_rst_busy", flush_busy, 0);
    chk("t8_rst_ready", lookup_ready, 1);
    chk("t8_rst_done", flush_done, 0);
    chk("t8_rst_rv", resp_valid, 0);
    @(negedge clk);
    #2 rst_n = 1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (flush_done) done_seen++;
    end
    chk("t8_no_done", done_seen, 0);
    lookup(2, 'h55);
    chk("t8_miss", resp_hit, 0);
    chk("t8_vw", resp_victim_way, 0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
